fpu_ss_offload_buffer: RTL and testbench

FPU_SS_OFFLOAD_BUFFER -- requirements
Module: fpu_ss_offload_buffer

---
 rtl/fpu_ss_offload_buffer.sv | 102 ++++++++++
 tb/tb_fpu_ss_offload_buffer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fpu_ss_offload_buffer.sv
// Offload request FIFO between the X-interface issue side and the FPU subsystem decoder.
// Optional same-cycle bypass on an empty buffer: define FPU_SS_OFFLOAD_BUFFER_FALLTHROUGH_EN.

package fpu_ss_pkg;

  typedef struct packed {
    logic [2:0][31:0] rs;
    logic [31:0]      instr_data;
    logic [3:0]       id;
    logic [1:0]       mode;
  } offloaded_data_t;

endpackage

module fpu_ss_offload_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          flush_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  fpu_ss_pkg::offloaded_data_t   in_data_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output fpu_ss_pkg::offloaded_data_t   out_data_o,
  output logic [$clog2(DEPTH):0]        usage_o,
  output logic                          full_o,
  output logic                          empty_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] UsageFull = (PtrW + 1)'(DEPTH);

  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]   usage_q, usage_d;

  fpu_ss_pkg::offloaded_data_t mem_q [DEPTH];

  logic push;
  logic store;
  logic pop_mem;

  assign full_o     = (usage_q == UsageFull);
  assign empty_o    = (usage_q == '0);
  assign usage_o    = usage_q;
  assign in_ready_o = !full_o;
  assign push       = in_valid_i & in_ready_o;

`ifdef FPU_SS_OFFLOAD_BUFFER_FALLTHROUGH_EN
  logic bypass;

  // An empty buffer presents the incoming request directly; it is only stored if not taken.
  assign bypass      = empty_o & in_valid_i & !flush_i & rst_ni;
  assign out_valid_o = !empty_o | bypass;
  assign out_data_o  = bypass ? in_data_i : mem_q[rd_ptr_q];
  assign store       = push & !(bypass & out_ready_i);
  assign pop_mem     = !empty_o & out_ready_i;
`else
  assign out_valid_o = !empty_o;
  assign out_data_o  = mem_q[rd_ptr_q];
  assign store       = push;
  assign pop_mem     = out_valid_o & out_ready_i;
`endif

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    usage_d  = usage_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      usage_d  = '0;
    end else begin
      // Power-of-two depth: pointers wrap naturally at DEPTH-1.
      if (store) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop_mem) rd_ptr_d = rd_ptr_q + PtrW'(1);
      usage_d = usage_q + (PtrW + 1)'(store) - (PtrW + 1)'(pop_mem);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      usage_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      usage_q  <= usage_d;
    end
  end

  // Storage is not reset; it is only written on an accepted, retained push.
  always_ff @(posedge clk_i) begin
    if (rst_ni && !flush_i && store) begin
      mem_q[wr_ptr_q] <= in_data_i;
    end
  end

endmodule

// File: tb/tb_fpu_ss_offload_buffer.sv
// Directed, table-driven bench for fpu_ss_offload_buffer (DEPTH=4).

module tb_fpu_ss_offload_buffer;

  import fpu_ss_pkg::*;

`ifdef FPU_SS_OFFLOAD_BUFFER_FALLTHROUGH_EN
  localparam bit Ft = 1'b1;
`else
  localparam bit Ft = 1'b0;
`endif

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            flush_i;
  logic            in_valid_i;
  logic            in_ready_o;
  offloaded_data_t in_data_i;
  logic            out_valid_o;
  logic            out_ready_i;
  offloaded_data_t out_data_o;
  logic [2:0]      usage_o;
  logic            full_o;
  logic            empty_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  fpu_ss_offload_buffer #(.DEPTH(4)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .usage_o     (usage_o),
    .full_o      (full_o),
    .empty_o     (empty_o)
  );

  function automatic offloaded_data_t mk(input int n);
    offloaded_data_t d;
    d.rs[0]      = 32'hDEAD_0000 + n;
    d.rs[1]      = 32'hBEEF_0000 + n;
    d.rs[2]      = 32'hC0DE_0000 ^ n;
    d.instr_data = 32'h1000_0000 | (n * 3);
    d.id         = 4'(n);
    d.mode       = 2'(n);
    return d;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_data(input string name, input offloaded_data_t act,
                          input offloaded_data_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    bit       rst;
    bit       flush;
    bit       iv;
    int       id;
    bit       ordy;
    bit       exp_ir;
    bit       exp_ov;
    int       exp_head;
    int       exp_usage;
  } vec_t;

  vec_t vecs [19];

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input bit rst, input bit fl, input bit iv, input int id, input bit ordy);
    @(negedge clk_i);
    rst_ni      = !rst;
    flush_i     = fl;
    in_valid_i  = iv;
    in_data_i   = mk(id);
    out_ready_i = ordy;
    #1;
  endtask

  initial begin
    offloaded_data_t exp_q[$];
    int received;

    //          rst flush iv id  ordy ir  ov  head usage
    vecs[0]  = '{0, 0, 1, 1,  0, 1, Ft, 1, 0};   // first push into empty buffer
    vecs[1]  = '{0, 0, 1, 2,  0, 1, 1,  1, 1};
    vecs[2]  = '{0, 0, 1, 3,  0, 1, 1,  1, 2};
    vecs[3]  = '{0, 0, 1, 4,  0, 1, 1,  1, 3};
    vecs[4]  = '{0, 0, 1, 5,  0, 0, 1,  1, 4};   // full: 5th refused
    vecs[5]  = '{0, 0, 1, 6,  1, 0, 1,  1, 4};   // full + pop: push still refused
    vecs[6]  = '{0, 0, 0, 0,  1, 1, 1,  2, 3};
    vecs[7]  = '{0, 0, 0, 0,  1, 1, 1,  3, 2};
    vecs[8]  = '{0, 0, 0, 0,  1, 1, 1,  4, 1};
    vecs[9]  = '{0, 0, 0, 0,  0, 1, 0,  0, 0};
    vecs[10] = '{0, 0, 1, 7,  0, 1, Ft, 7, 0};
    vecs[11] = '{0, 0, 1, 8,  0, 1, 1,  7, 1};
    vecs[12] = '{0, 0, 1, 9,  0, 1, 1,  7, 2};
    vecs[13] = '{0, 1, 1, 10, 0, 1, 1,  7, 3};   // flush cycle shows pre-flush state
    vecs[14] = '{0, 0, 0, 0,  0, 1, 0,  0, 0};
    vecs[15] = '{0, 0, 1, 11, 0, 1, Ft, 11, 0};
    vecs[16] = '{0, 0, 1, 12, 0, 1, 1,  11, 1};
    vecs[17] = '{1, 0, 0, 0,  1, 1, 1,  11, 2};  // mid-operation reset
    vecs[18] = '{0, 0, 0, 0,  0, 1, 0,  0, 0};

    rst_ni = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0; in_data_i = mk(0);
    repeat (2) @(posedge clk_i);

    // Post-reset state.
    drive(0, 0, 0, 0, 0);
    chk("rst in_ready", 32'(in_ready_o), 1);
    chk("rst out_valid", 32'(out_valid_o), 0);
    chk("rst usage", 32'(usage_o), 0);
    chk("rst empty", 32'(empty_o), 1);
    chk("rst full", 32'(full_o), 0);

    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].rst, vecs[i].flush, vecs[i].iv, vecs[i].id, vecs[i].ordy);
      chk($sformatf("v%0d in_ready", i), 32'(in_ready_o), 32'(vecs[i].exp_ir));
      chk($sformatf("v%0d out_valid", i), 32'(out_valid_o), 32'(vecs[i].exp_ov));
      chk($sformatf("v%0d usage", i), 32'(usage_o), 32'(vecs[i].exp_usage));
      chk($sformatf("v%0d full", i), 32'(full_o), 32'(vecs[i].exp_usage == 4));
      chk($sformatf("v%0d empty", i), 32'(empty_o), 32'(vecs[i].exp_usage == 0));
      if (vecs[i].exp_ov)
        chk_data($sformatf("v%0d head", i), out_data_o, mk(vecs[i].exp_head));
    end

    // Continuous streaming: pointers wrap, order and bit-exactness preserved.
    received = 0;
    for (int c = 0; c < 12; c++) begin
      drive(0, 0, c < 10, c + 20, 1);
      if (c < 10) exp_q.push_back(mk(c + 20));
      chk($sformatf("stream%0d usage", c), 32'(usage_o),
          (Ft || c == 0 || c == 11) ? 0 : 1);
      if (out_valid_o && exp_q.size() > 0) begin
        chk_data($sformatf("stream%0d data", c), out_data_o, exp_q.pop_front());
        received++;
      end
    end
    chk("stream count", 32'(received), 10);

`ifdef FPU_SS_OFFLOAD_BUFFER_FALLTHROUGH_EN
    // Same-cycle bypass on empty buffer, consumed without storing.
    drive(0, 0, 1, 7, 1);
    chk("ft out_valid", 32'(out_valid_o), 1);
    chk("ft id", 32'(out_data_o.id), 7);
    drive(0, 0, 0, 0, 0);
    chk("ft usage", 32'(usage_o), 0);
    chk("ft out_valid after", 32'(out_valid_o), 0);
`else
    // Output valid rises only the cycle after the push.
    drive(0, 0, 1, 7, 1);
    chk("lat out_valid same", 32'(out_valid_o), 0);
    drive(0, 0, 0, 0, 1);
    chk("lat out_valid next", 32'(out_valid_o), 1);
    chk("lat id", 32'(out_data_o.id), 7);
    drive(0, 0, 0, 0, 0);
    chk("lat usage", 32'(usage_o), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
